// File: rtl/ram128_byte_arbiter_if.sv
// ----------------------------------------------------------------------------
// ram128_byte_arbiter_if
// Bundles the two requester ports and the RAM128 byte-wrapper port of the
// ram128_byte_arbiter.
//   R0_*/R1_*  : VALID/READY request handshake, WE/ADDR/SIZE/WDATA command,
//                DONE completion pulse and assembled RDATA.
//   MEM_*      : byte-wide RAM wrapper port (WE/A/DI out of arbiter, DO in).
// Modports:
//   slave  - the arbiter side.
//   master - requesters plus the RAM wrapper (environment side).
// ----------------------------------------------------------------------------
interface ram128_byte_arbiter_if;
    logic        R0_VALID, R1_VALID;
    logic        R0_READY, R1_READY;
    logic        R0_WE,    R1_WE;
    logic [8:0]  R0_ADDR,  R1_ADDR;
    logic [1:0]  R0_SIZE,  R1_SIZE;
    logic [31:0] R0_WDATA, R1_WDATA;
    logic        R0_DONE,  R1_DONE;
    logic [31:0] R0_RDATA, R1_RDATA;
    logic        MEM_WE;
    logic [8:0]  MEM_A;
    logic [7:0]  MEM_DI;
    logic [7:0]  MEM_DO;

    modport slave (
        input  R0_VALID, R0_WE, R0_ADDR, R0_SIZE, R0_WDATA,
        input  R1_VALID, R1_WE, R1_ADDR, R1_SIZE, R1_WDATA,
        input  MEM_DO,
        output R0_READY, R0_DONE, R0_RDATA,
        output R1_READY, R1_DONE, R1_RDATA,
        output MEM_WE, MEM_A, MEM_DI
    );

    modport master (
        output R0_VALID, R0_WE, R0_ADDR, R0_SIZE, R0_WDATA,
        output R1_VALID, R1_WE, R1_ADDR, R1_SIZE, R1_WDATA,
        output MEM_DO,
        input  R0_READY, R0_DONE, R0_RDATA,
        input  R1_READY, R1_DONE, R1_RDATA,
        input  MEM_WE, MEM_A, MEM_DI
    );
endinterface

// File: rtl/ram128_byte_arbiter.sv
// ----------------------------------------------------------------------------
// ram128_byte_arbiter
// Round-robin arbiter between two requesters sharing a byte-wide RAM wrapper.
// Each accepted request is split into 1/2/4 byte beats (byte/half/word),
// issued one per cycle with wrap-around addressing; read bytes returning
// READ_LAT cycles later are assembled little-endian into the owner's RDATA.
// Ports:
//   CLK       - sole clock, rising edge.
//   RST       - synchronous active-high reset; aborts any transaction.
//   bus       - requester handshakes/commands/completions and RAM port.
// Parameter:
//   READ_LAT  - cycles from MEM_A to valid MEM_DO (1..3).
// ----------------------------------------------------------------------------
module ram128_byte_arbiter #(
    parameter int unsigned READ_LAT = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    ram128_byte_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

    state_t      state_q;
    logic        ptr_q, gnt_q, we_q;
    logic [8:0]  addr_q;
    logic [1:0]  last_q, beat_q;
    logic [31:0] wdata_q, asm_q, rd0_q, rd1_q;
    logic        done0_q, done1_q;

    // Read-return tracker: valid bit and byte index per outstanding beat.
    logic [READ_LAT-1:0] pv_q;
    logic [1:0]          pi_q [READ_LAT];

    logic        gnt_d, accept, issuing, cap, cap_last;
    logic [1:0]  cap_idx, size_sel, last_d;
    logic [31:0] asm_d;

    // Contention follows the pointer; a sole requester always wins.
    always_comb begin
        gnt_d = (bus.R0_VALID && bus.R1_VALID) ? ptr_q : bus.R1_VALID;
        accept = (state_q == IDLE) && !RST && (bus.R0_VALID || bus.R1_VALID);
        size_sel = gnt_d ? bus.R1_SIZE : bus.R0_SIZE;
        case (size_sel)
            2'b01:   last_d = 2'd1;
            2'b10:   last_d = 2'd3;
            default: last_d = 2'd0;
        endcase
    end

    assign bus.R0_READY = accept && !gnt_d;
    assign bus.R1_READY = accept &&  gnt_d;

    assign issuing    = (state_q == ISSUE);
    assign bus.MEM_WE = issuing && we_q;
    assign bus.MEM_A  = issuing ? addr_q + {7'd0, beat_q} : '0;
    assign bus.MEM_DI = issuing ? wdata_q[{beat_q, 3'b000} +: 8] : '0;

    assign cap      = pv_q[READ_LAT-1];
    assign cap_idx  = pi_q[READ_LAT-1];
    assign cap_last = cap && (cap_idx == last_q);

    always_comb begin
        asm_d = asm_q;
        if (cap) asm_d[{cap_idx, 3'b000} +: 8] = bus.MEM_DO;
    end

    assign bus.R0_DONE  = done0_q;
    assign bus.R1_DONE  = done1_q;
    assign bus.R0_RDATA = rd0_q;
    assign bus.R1_RDATA = rd1_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            gnt_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            last_q  <= '0;
            beat_q  <= '0;
            wdata_q <= '0;
            asm_q   <= '0;
            rd0_q   <= '0;
            rd1_q   <= '0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            pv_q    <= '0;
            for (int unsigned k = 0; k < READ_LAT; k++) pi_q[k] <= '0;
        end else begin
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            asm_q   <= asm_d;
            pv_q[0] <= issuing && !we_q;
            pi_q[0] <= beat_q;
            for (int unsigned k = 1; k < READ_LAT; k++) begin
                pv_q[k] <= pv_q[k-1];
                pi_q[k] <= pi_q[k-1];
            end
            case (state_q)
                IDLE: if (accept) begin
                    gnt_q   <= gnt_d;
                    ptr_q   <= ~gnt_d;
                    we_q    <= gnt_d ? bus.R1_WE    : bus.R0_WE;
                    addr_q  <= gnt_d ? bus.R1_ADDR  : bus.R0_ADDR;
                    wdata_q <= gnt_d ? bus.R1_WDATA : bus.R0_WDATA;
                    last_q  <= last_d;
                    beat_q  <= '0;
                    asm_q   <= '0;
                    state_q <= ISSUE;
                end
                ISSUE: begin
                    beat_q <= beat_q + 2'd1;
                    if (beat_q == last_q) begin
                        if (we_q) begin
                            state_q <= RESP;
                            done0_q <= !gnt_q;
                            done1_q <= gnt_q;
                        end else begin
                            state_q <= DRAIN;
                        end
                    end
                end
                // The final byte lands on the same edge that enters RESP, so
                // RDATA is loaded from the merged value, not asm_q.
                DRAIN: if (cap_last) begin
                    state_q <= RESP;
                    done0_q <= !gnt_q;
                    done1_q <= gnt_q;
                    if (gnt_q) rd1_q <= asm_d;
                    else       rd0_q <= asm_d;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram128_byte_arbiter.sv
module tb_ram128_byte_arbiter;
    localparam int LAT = 2;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    ram128_byte_arbiter_if bus ();

    ram128_byte_arbiter #(.READ_LAT(LAT)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // RAM wrapper model: byte write on posedge, read data LAT cycles after address.
    logic [7:0] mem [512];
    logic [8:0] ap  [LAT];
    always @(posedge CLK) begin
        if (bus.MEM_WE) mem[bus.MEM_A] <= bus.MEM_DI;
        ap[0] <= bus.MEM_A;
        for (int k = 1; k < LAT; k++) ap[k] <= ap[k-1];
    end
    assign bus.MEM_DO = mem[ap[LAT-1]];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic clear_reqs();
        bus.R0_VALID = 0; bus.R0_WE = 0; bus.R0_ADDR = '0; bus.R0_SIZE = '0; bus.R0_WDATA = '0;
        bus.R1_VALID = 0; bus.R1_WE = 0; bus.R1_ADDR = '0; bus.R1_SIZE = '0; bus.R1_WDATA = '0;
    endtask

    // One transaction from an IDLE cycle; ends at the negedge of the following IDLE cycle.
    task automatic xact(input int r, input logic we, input logic [8:0] addr, input logic [1:0] size,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input logic [31:0] exp_other);
        int n, lat;
        logic [8:0] ea;
        n   = (size == 2'b01) ? 2 : (size == 2'b10) ? 4 : 1;
        lat = we ? n + 1 : n + LAT + 1;
        if (r == 0) begin
            bus.R0_VALID = 1; bus.R0_WE = we; bus.R0_ADDR = addr; bus.R0_SIZE = size; bus.R0_WDATA = wd;
        end else begin
            bus.R1_VALID = 1; bus.R1_WE = we; bus.R1_ADDR = addr; bus.R1_SIZE = size; bus.R1_WDATA = wd;
        end
        #1;
        check("ready_own",   32'(r == 0 ? bus.R0_READY : bus.R1_READY), 32'd1);
        check("ready_other", 32'(r == 0 ? bus.R1_READY : bus.R0_READY), 32'd0);
        for (int c = 1; c <= lat; c++) begin
            tick();
            if (c == 1) begin
                // Post-acceptance changes must be ignored.
                bus.R0_VALID = 0; bus.R1_VALID = 0;
                bus.R0_ADDR = ~addr; bus.R1_ADDR = ~addr; bus.R0_SIZE = 2'b00; bus.R1_SIZE = 2'b00;
            end
            #1;
            if (c <= n) begin
                ea = addr + 9'(c - 1);
                check("beat_we", 32'(bus.MEM_WE), 32'(we));
                check("beat_a",  32'(bus.MEM_A), 32'(ea));
                check("beat_di", 32'(bus.MEM_DI), we ? 32'(wd[8*(c-1) +: 8]) : 32'd0);
            end else begin
                check("bus_idle", {15'd0, bus.MEM_WE, bus.MEM_A, bus.MEM_DI}, 32'd0);
            end
            check("done_own",   32'(r == 0 ? bus.R0_DONE : bus.R1_DONE), 32'(c == lat));
            check("done_other", 32'(r == 0 ? bus.R1_DONE : bus.R0_DONE), 32'd0);
            if (c == lat) begin
                if (!we) check("rdata_own", r == 0 ? bus.R0_RDATA : bus.R1_RDATA, exp_rd);
                check("rdata_other", r == 0 ? bus.R1_RDATA : bus.R0_RDATA, exp_other);
            end
        end
        tick();
        #1;
        check("done_pulse", 32'(r == 0 ? bus.R0_DONE : bus.R1_DONE), 32'd0);
        tick();
    endtask

    initial begin
        int  grants, budget;
        logic both, seen0, seen1;

        clear_reqs();
        // Reset state, with a request pending while in reset.
        RST = 1;
        tick(); tick();
        bus.R0_VALID = 1;
        #1;
        check("rst_ready0", 32'(bus.R0_READY), 32'd0);
        check("rst_done",   {30'd0, bus.R0_DONE, bus.R1_DONE}, 32'd0);
        check("rst_mem",    {15'd0, bus.MEM_WE, bus.MEM_A, bus.MEM_DI}, 32'd0);
        check("rst_rdata0", bus.R0_RDATA, 32'd0);
        check("rst_rdata1", bus.R1_RDATA, 32'd0);
        bus.R0_VALID = 0;
        tick();
        RST = 0;
        tick();

        // Word write, word read back, wrapping word write, wrapping half read.
        xact(0, 1'b1, 9'h010, 2'b10, 32'hDDCCBBAA, 32'd0, 32'd0);
        xact(1, 1'b0, 9'h010, 2'b10, 32'd0, 32'hDDCCBBAA, 32'd0);
        xact(1, 1'b1, 9'h1FE, 2'b10, 32'h44332211, 32'd0, 32'd0);
        xact(0, 1'b0, 9'h1FF, 2'b01, 32'd0, 32'h00003322, 32'hDDCCBBAA);

        // Round robin from reset with both requesters permanently valid.
        RST = 1;
        tick(); tick();
        RST = 0;
        bus.R0_VALID = 1; bus.R0_WE = 0; bus.R0_ADDR = 9'h010; bus.R0_SIZE = 2'b00;
        bus.R1_VALID = 1; bus.R1_WE = 0; bus.R1_ADDR = 9'h011; bus.R1_SIZE = 2'b00;
        grants = 0; budget = 0; both = 0;
        while (grants < 4 && budget < 40) begin
            #1;
            if (bus.R0_READY && bus.R1_READY) both = 1;
            else if (bus.R0_READY || bus.R1_READY) begin
                check("rr_grant", 32'(bus.R1_READY), 32'(grants % 2));
                grants++;
            end
            tick();
            budget++;
        end
        check("rr_grants", 32'(grants), 32'd4);
        check("rr_both_ready", 32'(both), 32'd0);
        clear_reqs();
        for (int i = 0; i < 6; i++) tick();
        check("rr_rdata0", bus.R0_RDATA, 32'h000000AA);
        check("rr_rdata1", bus.R1_RDATA, 32'h000000BB);

        // Reset during beat 2 of a word read aborts it.
        bus.R0_VALID = 1; bus.R0_WE = 0; bus.R0_ADDR = 9'h010; bus.R0_SIZE = 2'b10;
        #1;
        check("abort_ready", 32'(bus.R0_READY), 32'd1);
        tick();
        bus.R0_VALID = 0;
        tick();
        tick();
        #1;
        check("abort_beat2_a", 32'(bus.MEM_A), 32'h012);
        RST = 1;
        tick();
        #1;
        check("abort_mem", {15'd0, bus.MEM_WE, bus.MEM_A, bus.MEM_DI}, 32'd0);
        RST = 0;
        seen0 = 0; seen1 = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            #1;
            if (bus.R0_DONE) seen0 = 1;
            if (bus.R1_DONE) seen1 = 1;
        end
        check("abort_no_done", {30'd0, seen0, seen1}, 32'd0);
        check("abort_rdata0", bus.R0_RDATA, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
